// File: rtl/prim_pkg.sv
// prim_pkg: shared types, default widths and helpers for the primitive assembler.
package prim_pkg;

    localparam int unsigned XY_W_DEF      = 16;
    localparam int unsigned Z_W_DEF       = 8;
    localparam int unsigned UV_W_DEF      = 32;
    localparam int unsigned VTX_W_DEF     = 2 * XY_W_DEF + Z_W_DEF + 2 * UV_W_DEF;
    // Width of the {x,y} key handed to the degenerate-triangle comparator (covers XY_W <= 32).
    localparam int unsigned XY_PAIR_MAX_W = 64;
    localparam int unsigned CNT_W         = 16;

    typedef enum logic [1:0] {
        TOPO_LIST  = 2'd0,
        TOPO_STRIP = 2'd1,
        TOPO_FAN   = 2'd2
    } topo_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_LOAD  = 2'd1,
        ST_EMIT  = 2'd2
    } state_e;

    // Vertex layout at default widths, x in the MSBs.
    typedef struct packed {
        logic signed [XY_W_DEF-1:0] x;
        logic signed [XY_W_DEF-1:0] y;
        logic [Z_W_DEF-1:0]         z;
        logic [UV_W_DEF-1:0]        u;
        logic [UV_W_DEF-1:0]        v;
    } vertex_t;

    function automatic logic signed [XY_W_DEF-1:0] vtx_x(input vertex_t vtx);
        return vtx.x;
    endfunction

    function automatic logic signed [XY_W_DEF-1:0] vtx_y(input vertex_t vtx);
        return vtx.y;
    endfunction

    function automatic logic [Z_W_DEF-1:0] vtx_z(input vertex_t vtx);
        return vtx.z;
    endfunction

    function automatic logic [UV_W_DEF-1:0] vtx_u(input vertex_t vtx);
        return vtx.u;
    endfunction

    function automatic logic [UV_W_DEF-1:0] vtx_v(input vertex_t vtx);
        return vtx.v;
    endfunction

    // Mode 3 is reserved and falls back to list topology.
    function automatic topo_e decode_mode(input logic [1:0] mode);
        case (mode)
            2'd1:    return TOPO_STRIP;
            2'd2:    return TOPO_FAN;
            default: return TOPO_LIST;
        endcase
    endfunction

    // True when any two of the three {x,y} keys coincide.
    function automatic logic tri_degenerate(input logic [XY_PAIR_MAX_W-1:0] a,
                                            input logic [XY_PAIR_MAX_W-1:0] b,
                                            input logic [XY_PAIR_MAX_W-1:0] c);
        return (a == b) || (a == c) || (b == c);
    endfunction

endpackage

// File: rtl/prim_assembler.sv
// prim_assembler: pops packed vertices from the vertex FIFO, assembles list/strip/fan
// triangles and hands them to the rasterizer over a valid/busy handshake.
// Optional build macro PRIM_ASSEMBLER_DEGEN_CULL_EN: culls triangles with coincident
// (x,y) vertices and exposes o_cull_count.
module prim_assembler
    import prim_pkg::*;
#(
    parameter  int unsigned XY_W  = XY_W_DEF,
    parameter  int unsigned Z_W   = Z_W_DEF,
    parameter  int unsigned UV_W  = UV_W_DEF,
    localparam int unsigned VTX_W = 2 * XY_W + Z_W + 2 * UV_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [1:0]       i_mode,
    input  logic             i_restart,
    input  logic [VTX_W-1:0] i_fifo_data,
    input  logic             i_fifo_empty,
    output logic             o_fifo_read,
    output logic             o_tri_valid,
    input  logic             i_raster_busy,
    output logic [VTX_W-1:0] o_vtx0,
    output logic [VTX_W-1:0] o_vtx1,
    output logic [VTX_W-1:0] o_vtx2,
    output logic [15:0]      o_tri_count
`ifdef PRIM_ASSEMBLER_DEGEN_CULL_EN
    ,
    output logic [15:0]      o_cull_count
`endif
);

    state_e             state_q, state_d;
    topo_e              mode_q, mode_d;
    logic [1:0]         vcount_q, vcount_d;
    logic               parity_q, parity_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   count_q, count_d;
    // s0 holds list slot 0 / strip n-2 / fan pivot; s1 holds list slot 1 / n-1.
    logic [VTX_W-1:0]   s0_q, s0_d;
    logic [VTX_W-1:0]   s1_q, s1_d;
    logic [VTX_W-1:0]   vtx0_q, vtx0_d;
    logic [VTX_W-1:0]   vtx1_q, vtx1_d;
    logic [VTX_W-1:0]   vtx2_q, vtx2_d;
`ifdef PRIM_ASSEMBLER_DEGEN_CULL_EN
    logic [CNT_W-1:0]   cull_q, cull_d;
`endif

    // Pop strobe: only FETCH may read, at most one read in flight.
    assign o_fifo_read = (state_q == ST_FETCH) && !i_fifo_empty;
    assign o_tri_valid = valid_q;
    assign o_vtx0      = vtx0_q;
    assign o_vtx1      = vtx1_q;
    assign o_vtx2      = vtx2_q;
    assign o_tri_count = count_q;
`ifdef PRIM_ASSEMBLER_DEGEN_CULL_EN
    assign o_cull_count = cull_q;
`endif

    // Next-state, slot selection and handshake bookkeeping.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        vcount_d = vcount_q;
        parity_d = parity_q;
        valid_d  = valid_q;
        count_d  = count_q;
        s0_d     = s0_q;
        s1_d     = s1_q;
        vtx0_d   = vtx0_q;
        vtx1_d   = vtx1_q;
        vtx2_d   = vtx2_q;
`ifdef PRIM_ASSEMBLER_DEGEN_CULL_EN
        cull_d   = cull_q;
`endif

        if (i_restart) begin
            // Restart wins over everything: drop partial/pending work, including a word in flight.
            state_d  = ST_FETCH;
            mode_d   = decode_mode(i_mode);
            vcount_d = 2'd0;
            parity_d = 1'b0;
            valid_d  = 1'b0;
            count_d  = '0;
`ifdef PRIM_ASSEMBLER_DEGEN_CULL_EN
            cull_d   = '0;
`endif
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (!i_fifo_empty) state_d = ST_LOAD;
                end

                ST_LOAD: begin
                    vcount_d = (vcount_q == 2'd3) ? 2'd3 : vcount_q + 2'd1;
                    state_d  = ST_FETCH;
                    if (vcount_q == 2'd0) begin
                        s0_d = i_fifo_data;
                    end else if (vcount_q == 2'd1) begin
                        s1_d = i_fifo_data;
                    end else begin
                        state_d = ST_EMIT;
                        vtx2_d  = i_fifo_data;
                        // Odd strip triangles swap the first two vertices to keep winding.
                        if ((mode_q == TOPO_STRIP) && parity_q) begin
                            vtx0_d = s1_q;
                            vtx1_d = s0_q;
                        end else begin
                            vtx0_d = s0_q;
                            vtx1_d = s1_q;
                        end
                        if (mode_q == TOPO_STRIP) s0_d = s1_q;
                        if (mode_q != TOPO_LIST)  s1_d = i_fifo_data;
`ifdef PRIM_ASSEMBLER_DEGEN_CULL_EN
                        valid_d = !tri_degenerate(
                            XY_PAIR_MAX_W'(vtx0_d[VTX_W-1 -: 2*XY_W]),
                            XY_PAIR_MAX_W'(vtx1_d[VTX_W-1 -: 2*XY_W]),
                            XY_PAIR_MAX_W'(vtx2_d[VTX_W-1 -: 2*XY_W]));
`else
                        valid_d = 1'b1;
`endif
                    end
                end

                ST_EMIT: begin
`ifdef PRIM_ASSEMBLER_DEGEN_CULL_EN
                    // EMIT entered without valid means the triangle was culled.
                    if (!valid_q) begin
                        state_d  = ST_FETCH;
                        parity_d = ~parity_q;
                        cull_d   = cull_q + CNT_W'(1);
                        if (mode_q == TOPO_LIST) vcount_d = 2'd0;
                    end else
`endif
                    if (!i_raster_busy) begin
                        state_d  = ST_FETCH;
                        valid_d  = 1'b0;
                        count_d  = count_q + CNT_W'(1);
                        parity_d = ~parity_q;
                        if (mode_q == TOPO_LIST) vcount_d = 2'd0;
                    end
                end

                default: state_d = ST_FETCH;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end

    // Control, vertex history and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mode_q   <= TOPO_LIST;
            vcount_q <= 2'd0;
            parity_q <= 1'b0;
            valid_q  <= 1'b0;
            count_q  <= '0;
            s0_q     <= '0;
            s1_q     <= '0;
            vtx0_q   <= '0;
            vtx1_q   <= '0;
            vtx2_q   <= '0;
`ifdef PRIM_ASSEMBLER_DEGEN_CULL_EN
            cull_q   <= '0;
`endif
        end else begin
            mode_q   <= mode_d;
            vcount_q <= vcount_d;
            parity_q <= parity_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
            s0_q     <= s0_d;
            s1_q     <= s1_d;
            vtx0_q   <= vtx0_d;
            vtx1_q   <= vtx1_d;
            vtx2_q   <= vtx2_d;
`ifdef PRIM_ASSEMBLER_DEGEN_CULL_EN
            cull_q   <= cull_d;
`endif
        end
    end

endmodule

// File: tb/tb_prim_assembler.sv
// tb_prim_assembler: directed bench for prim_assembler with a queue-based vertex FIFO model.
module tb_prim_assembler;
    import prim_pkg::*;

    localparam int unsigned VTX_W = VTX_W_DEF;
    localparam int unsigned TRI_W = 3 * VTX_W;
    localparam int unsigned CW    = TRI_W + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       mode;
    logic             restart;
    logic [VTX_W-1:0] fifo_data;
    logic             fifo_empty;
    logic             fifo_read;
    logic             tri_valid;
    logic             raster_busy;
    logic [VTX_W-1:0] vtx0, vtx1, vtx2;
    logic [15:0]      tri_count;
`ifdef PRIM_ASSEMBLER_DEGEN_CULL_EN
    logic [15:0]      cull_count;
`endif

    always #5 clk = ~clk;

    prim_assembler dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_mode        (mode),
        .i_restart     (restart),
        .i_fifo_data   (fifo_data),
        .i_fifo_empty  (fifo_empty),
        .o_fifo_read   (fifo_read),
        .o_tri_valid   (tri_valid),
        .i_raster_busy (raster_busy),
        .o_vtx0        (vtx0),
        .o_vtx1        (vtx1),
        .o_vtx2        (vtx2),
        .o_tri_count   (tri_count)
`ifdef PRIM_ASSEMBLER_DEGEN_CULL_EN
        ,
        .o_cull_count  (cull_count)
`endif
    );

    logic [VTX_W-1:0] fifo_q[$];
    logic [TRI_W-1:0] got_q[$];
    int               checks  = 0;
    int               errors  = 0;
    int               pops    = 0;
    int               rd_viol = 0;
    logic             rd_prev = 1'b0;

    function automatic logic [VTX_W-1:0] mk_vtx(input int x, input int y, input int t);
        vertex_t v;
        v.x = XY_W_DEF'(x);
        v.y = XY_W_DEF'(y);
        v.z = Z_W_DEF'(t);
        v.u = UV_W_DEF'(32'hC0DE_0000 + t);
        v.v = UV_W_DEF'(~t);
        return v;
    endfunction

    function automatic logic [VTX_W-1:0] std_vtx(input int x);
        return mk_vtx(x, x + 100, x);
    endfunction

    function automatic logic [TRI_W-1:0] exp_tri(input int a, input int b, input int c);
        return {std_vtx(a), std_vtx(b), std_vtx(c)};
    endfunction

    function automatic logic [TRI_W-1:0] tri_at(input int k);
        if (k < got_q.size()) return got_q[k];
        return 'x;
    endfunction

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, then update the FIFO model after the rising edge.
    task automatic tick();
        logic rd;
        #4;
        rd = fifo_read;
        if (rd && (tri_valid || rd_prev)) rd_viol++;
        if (tri_valid && !raster_busy) got_q.push_back({vtx0, vtx1, vtx2});
        rd_prev = rd;
        @(posedge clk);
        #1;
        if (rd && (fifo_q.size() > 0)) begin
            fifo_data = fifo_q.pop_front();
            pops++;
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic push(input logic [VTX_W-1:0] v);
        fifo_q.push_back(v);
        fifo_empty = 1'b0;
    endtask

    task automatic do_restart(input logic [1:0] m);
        mode    = m;
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic run_xfers(input string tag, input int n, input int budget);
        int c;
        c = 0;
        while ((got_q.size() < n) && (c < budget)) begin
            tick();
            c++;
        end
        chk(tag, CW'(got_q.size()), CW'(n));
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int c;
        c = 0;
        while (!tri_valid && (c < budget)) begin
            tick();
            c++;
        end
        chk(tag, CW'(tri_valid), CW'(1));
    endtask

    initial begin
        logic [TRI_W-1:0] hold_tri;
        int               pops0;

        rst         = 1'b1;
        mode        = 2'd0;
        restart     = 1'b0;
        fifo_data   = '0;
        fifo_empty  = 1'b1;
        raster_busy = 1'b0;
        @(posedge clk);
        #1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_valid", CW'(tri_valid), CW'(0));
        chk("rst_count", CW'(tri_count), CW'(0));
        chk("rst_read",  CW'(fifo_read), CW'(0));
        chk("rst_vtx",   CW'({vtx0, vtx1, vtx2}), CW'(0));

        // List: 1..6 -> (1,2,3), (4,5,6)
        got_q.delete();
        for (int i = 1; i <= 6; i++) push(std_vtx(i));
        run_xfers("list_xfers", 2, 60);
        chk("list_t0", CW'(tri_at(0)), CW'(exp_tri(1, 2, 3)));
        chk("list_t1", CW'(tri_at(1)), CW'(exp_tri(4, 5, 6)));
        chk("list_count", CW'(tri_count), CW'(2));
        chk("list_x_field", CW'(vtx_x(vertex_t'(vtx2))), CW'(6));
        chk("list_read_phase", CW'(rd_viol), CW'(0));

        // Strip: 10..14 -> (10,11,12), (12,11,13), (12,13,14)
        do_restart(2'd1);
        chk("strip_restart_count", CW'(tri_count), CW'(0));
        got_q.delete();
        for (int i = 10; i <= 14; i++) push(std_vtx(i));
        run_xfers("strip_xfers", 3, 60);
        chk("strip_t0", CW'(tri_at(0)), CW'(exp_tri(10, 11, 12)));
        chk("strip_t1", CW'(tri_at(1)), CW'(exp_tri(12, 11, 13)));
        chk("strip_t2", CW'(tri_at(2)), CW'(exp_tri(12, 13, 14)));
        chk("strip_count", CW'(tri_count), CW'(3));

        // Fan: 20..24 -> (20,21,22), (20,22,23), (20,23,24)
        do_restart(2'd2);
        got_q.delete();
        for (int i = 20; i <= 24; i++) push(std_vtx(i));
        run_xfers("fan_xfers", 3, 60);
        chk("fan_t0", CW'(tri_at(0)), CW'(exp_tri(20, 21, 22)));
        chk("fan_t1", CW'(tri_at(1)), CW'(exp_tri(20, 22, 23)));
        chk("fan_t2", CW'(tri_at(2)), CW'(exp_tri(20, 23, 24)));
        chk("fan_count", CW'(tri_count), CW'(3));

        // List with rasterizer busy for 10 EMIT cycles
        do_restart(2'd0);
        got_q.delete();
        raster_busy = 1'b1;
        for (int i = 40; i <= 42; i++) push(std_vtx(i));
        wait_valid("busy_reach_emit", 30);
        pops0    = pops;
        hold_tri = exp_tri(40, 41, 42);
        for (int i = 0; i < 10; i++) begin
            chk("busy_hold", {tri_valid, vtx0, vtx1, vtx2}, {1'b1, hold_tri});
            if (i < 9) tick();
        end
        chk("busy_no_xfer", CW'(got_q.size()), CW'(0));
        raster_busy = 1'b0;
        tick();
        chk("busy_xfer", CW'(tri_at(0)), CW'(hold_tri));
        chk("busy_valid_drop", CW'(tri_valid), CW'(0));
        chk("busy_count", CW'(tri_count), CW'(1));
        chk("busy_no_extra_read", CW'(pops), CW'(pops0));

        // Strip then restart into fan while a triangle waits in EMIT
        do_restart(2'd1);
        got_q.delete();
        for (int i = 50; i <= 53; i++) push(std_vtx(i));
        run_xfers("rs_first_xfer", 1, 30);
        chk("rs_t0", CW'(tri_at(0)), CW'(exp_tri(50, 51, 52)));
        raster_busy = 1'b1;
        wait_valid("rs_reach_emit", 30);
        chk("rs_pending", CW'({vtx0, vtx1, vtx2}), CW'(exp_tri(52, 51, 53)));
        chk("rs_pending_count", CW'(tri_count), CW'(1));
        do_restart(2'd2);
        chk("rs_drop_valid", CW'(tri_valid), CW'(0));
        chk("rs_drop_count", CW'(tri_count), CW'(0));
        got_q.delete();
        raster_busy = 1'b0;
        for (int i = 30; i <= 32; i++) push(std_vtx(i));
        run_xfers("rs_fan_xfer", 1, 30);
        chk("rs_fan_t0", CW'(tri_at(0)), CW'(exp_tri(30, 31, 32)));
        chk("rs_fan_count", CW'(tri_count), CW'(1));
        push(std_vtx(33));
        run_xfers("rs_fan_xfer2", 2, 30);
        chk("rs_fan_t1", CW'(tri_at(1)), CW'(exp_tri(30, 32, 33)));

        // Restart coincident with a transfer: rasterizer takes it, counter still clears
        raster_busy = 1'b1;
        push(std_vtx(34));
        wait_valid("rs_co_emit", 30);
        got_q.delete();
        raster_busy = 1'b0;
        mode        = 2'd0;
        restart     = 1'b1;
        tick();
        restart     = 1'b0;
        chk("rs_co_xfer", CW'(tri_at(0)), CW'(exp_tri(30, 33, 34)));
        chk("rs_co_count", CW'(tri_count), CW'(0));
        chk("rs_co_valid", CW'(tri_valid), CW'(0));

        // Degenerate triangle followed by a normal one (list)
        do_restart(2'd0);
        got_q.delete();
        push(mk_vtx(5, 5, 1));
        push(mk_vtx(5, 5, 2));
        push(mk_vtx(9, 1, 3));
        push(mk_vtx(1, 2, 4));
        push(mk_vtx(3, 4, 5));
        push(mk_vtx(5, 6, 6));
`ifdef PRIM_ASSEMBLER_DEGEN_CULL_EN
        chk("cull_clear", CW'(cull_count), CW'(0));
        run_xfers("cull_xfers", 1, 60);
        for (int i = 0; i < 6; i++) tick();
        chk("cull_only_one", CW'(got_q.size()), CW'(1));
        chk("cull_next_tri", CW'(tri_at(0)),
            CW'({mk_vtx(1, 2, 4), mk_vtx(3, 4, 5), mk_vtx(5, 6, 6)}));
        chk("cull_count", CW'(cull_count), CW'(1));
        chk("cull_tri_count", CW'(tri_count), CW'(1));
`else
        run_xfers("degen_xfers", 2, 60);
        chk("degen_t0", CW'(tri_at(0)),
            CW'({mk_vtx(5, 5, 1), mk_vtx(5, 5, 2), mk_vtx(9, 1, 3)}));
        chk("degen_t1", CW'(tri_at(1)),
            CW'({mk_vtx(1, 2, 4), mk_vtx(3, 4, 5), mk_vtx(5, 6, 6)}));
        chk("degen_count", CW'(tri_count), CW'(2));
`endif
        chk("read_phase_total", CW'(rd_viol), CW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
